// File: rtl/data_cache_assoc_wb.sv
// N-way set-associative write-back data cache, line-burst refill/writeback.
// Optional DCACHE_STATS_EN adds hit/miss counters on hit_count_o/miss_count_o.
module data_cache_assoc_wb #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int WAYS       = 2,
   parameter int SETS       = 16,
   parameter int LINE_WORDS = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cpu_req_i,
   input  logic                    cpu_write_i,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] cpu_byte_en_i,
   output logic                    cpu_ready_o,
   output logic                    cpu_done_o,
   output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
   output logic                    mem_req_o,
   output logic                    mem_write_o,
   output logic [ADDR_WIDTH-1:0]   mem_addr_o,
   output logic [DATA_WIDTH-1:0]   mem_wdata_o,
   input  logic                    mem_ack_i,
   input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
   input  logic                    mem_rvalid_i,
   input  logic                    inval_i,
   input  logic [ADDR_WIDTH-1:0]   inval_addr_i,
   output logic                    inval_done_o
`ifdef DCACHE_STATS_EN
   ,
   output logic [31:0]             hit_count_o,
   output logic [31:0]             miss_count_o
`endif
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BO_W  = $clog2(BYTES);
   localparam int WO_W  = $clog2(LINE_WORDS);
   localparam int OFF_W = BO_W + WO_W;
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_WIDTH - OFF_W - IDX_W;
   localparam int WAY_W = $clog2(WAYS);
   localparam int LINES = WAYS * SETS;

   localparam logic [WO_W-1:0] LAST = WO_W'(LINE_WORDS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOOKUP = 3'd1;
   localparam logic [2:0] S_WB     = 3'd2;
   localparam logic [2:0] S_REFILL = 3'd3;
   localparam logic [2:0] S_INVAL  = 3'd4;

   logic [2:0]            state;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic                  req_write;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic [BYTES-1:0]      req_be;
   logic                  inval_wb;
   logic                  replay;
   logic [WAY_W-1:0]      vway;
   logic [WO_W-1:0]       beat;
   logic [7:0]            lfsr;
   logic [LINES-1:0]      valid;
   logic [LINES-1:0]      dirty;

   logic [TAG_W-1:0]      tag_mem  [LINES];
   logic [DATA_WIDTH-1:0] data_mem [LINES*LINE_WORDS];

   logic [IDX_W-1:0]       req_idx;
   logic [TAG_W-1:0]       req_tag;
   logic [WO_W-1:0]        req_word;
   logic                   hit;
   logic [WAY_W-1:0]       hit_way;
   logic                   free;
   logic [WAY_W-1:0]       free_way;
   logic [WAY_W-1:0]       victim;
   logic [WAY_W+IDX_W-1:0] hit_line;
   logic [WAY_W+IDX_W-1:0] v_line;
   logic [WAY_W+IDX_W-1:0] victim_line;
   logic [DATA_WIDTH-1:0]  hit_data;
   logic [DATA_WIDTH-1:0]  merged;
   logic [7:0]             lfsr_next;
   logic                   unused_bits;

   assign req_idx  = req_addr[OFF_W +: IDX_W];
   assign req_tag  = req_addr[OFF_W+IDX_W +: TAG_W];
   assign req_word = req_addr[BO_W +: WO_W];
   assign unused_bits = ^req_addr[BO_W-1:0];

   assign lfsr_next = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);

   // Tag compare across ways and lowest-index free way search
   always_comb begin
      hit      = 1'b0;
      hit_way  = '0;
      free     = 1'b0;
      free_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid[{WAY_W'(w), req_idx}] &&
             tag_mem[{WAY_W'(w), req_idx}] == req_tag && !hit) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
         if (!valid[{WAY_W'(w), req_idx}] && !free) begin
            free     = 1'b1;
            free_way = WAY_W'(w);
         end
      end
   end

   assign victim      = free ? free_way : lfsr[WAY_W-1:0];
   assign hit_line    = {hit_way, req_idx};
   assign v_line      = {vway, req_idx};
   assign victim_line = {victim, req_idx};
   assign hit_data    = data_mem[{hit_line, req_word}];

   // Byte-masked merge of store data into the hit word
   always_comb begin
      merged = hit_data;
      for (int b = 0; b < BYTES; b++) begin
         if (req_be[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
      end
   end

   assign cpu_ready_o = (state == S_IDLE);
   assign mem_req_o   = (state == S_WB) || (state == S_REFILL);
   assign mem_write_o = (state == S_WB);

   // Burst address and writeback data, zero outside bursts
   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (state == S_WB) begin
         mem_addr_o  = {tag_mem[v_line], req_idx, OFF_W'(0)};
         mem_wdata_o = data_mem[{v_line, beat}];
      end else if (state == S_REFILL) begin
         mem_addr_o = {req_tag, req_idx, OFF_W'(0)};
      end
   end

   // Data and tag arrays: store hits and refill beats, no reset
   always_ff @(posedge clk_i) begin
      if (state == S_LOOKUP && hit && req_write) begin
         data_mem[{hit_line, req_word}] <= merged;
      end
      if (state == S_REFILL && mem_rvalid_i) begin
         data_mem[{v_line, beat}] <= mem_rdata_i;
         if (beat == LAST) tag_mem[v_line] <= req_tag;
      end
   end

   // Control FSM, line state bits, victim LFSR and response registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= S_IDLE;
         req_addr     <= '0;
         req_write    <= 1'b0;
         req_wdata    <= '0;
         req_be       <= '0;
         inval_wb     <= 1'b0;
         replay       <= 1'b0;
         vway         <= '0;
         beat         <= '0;
         lfsr         <= 8'h01;
         valid        <= '0;
         dirty        <= '0;
         cpu_done_o   <= 1'b0;
         cpu_rdata_o  <= '0;
         inval_done_o <= 1'b0;
      end else begin
         lfsr         <= lfsr_next;
         cpu_done_o   <= 1'b0;
         inval_done_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (inval_i) begin
                  req_addr <= inval_addr_i;
                  state    <= S_INVAL;
               end else if (cpu_req_i) begin
                  req_addr  <= cpu_addr_i;
                  req_write <= cpu_write_i;
                  req_wdata <= cpu_wdata_i;
                  req_be    <= cpu_byte_en_i;
                  replay    <= 1'b0;
                  state     <= S_LOOKUP;
               end
            end
            S_LOOKUP: begin
               if (hit) begin
                  if (req_write) dirty[hit_line] <= 1'b1;
                  else cpu_rdata_o <= hit_data;
                  cpu_done_o <= 1'b1;
                  state      <= S_IDLE;
               end else begin
                  vway     <= victim;
                  beat     <= '0;
                  inval_wb <= 1'b0;
                  if (valid[victim_line] && dirty[victim_line]) state <= S_WB;
                  else state <= S_REFILL;
               end
            end
            S_INVAL: begin
               if (hit && dirty[hit_line]) begin
                  vway     <= hit_way;
                  beat     <= '0;
                  inval_wb <= 1'b1;
                  state    <= S_WB;
               end else begin
                  if (hit) valid[hit_line] <= 1'b0;
                  inval_done_o <= 1'b1;
                  state        <= S_IDLE;
               end
            end
            S_WB: begin
               if (mem_ack_i) begin
                  beat <= beat + WO_W'(1);
                  if (beat == LAST) begin
                     dirty[v_line] <= 1'b0;
                     if (inval_wb) begin
                        valid[v_line] <= 1'b0;
                        inval_done_o  <= 1'b1;
                        state         <= S_IDLE;
                     end else begin
                        state <= S_REFILL;
                     end
                  end
               end
            end
            S_REFILL: begin
               if (mem_rvalid_i) begin
                  beat <= beat + WO_W'(1);
                  if (beat == LAST) begin
                     valid[v_line] <= 1'b1;
                     dirty[v_line] <= 1'b0;
                     replay        <= 1'b1;
                     state         <= S_LOOKUP;
                  end else begin
                     valid[v_line] <= 1'b0;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef DCACHE_STATS_EN
   // Saturating hit/miss counters, first lookup of a CPU request only
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         hit_count_o  <= '0;
         miss_count_o <= '0;
      end else if (state == S_LOOKUP && !replay) begin
         if (hit) begin
            if (hit_count_o != 32'hFFFF_FFFF) hit_count_o <= hit_count_o + 32'd1;
         end else begin
            if (miss_count_o != 32'hFFFF_FFFF) miss_count_o <= miss_count_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_data_cache_assoc_wb.sv
// Self-checking bench for data_cache_assoc_wb: vector table, corner
// sequences and randomized traffic against a flat golden memory.
module tb_data_cache_assoc_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req_i = 1'b0;
   logic        cpu_write_i = 1'b0;
   logic [31:0] cpu_addr_i = '0;
   logic [31:0] cpu_wdata_i = '0;
   logic [3:0]  cpu_byte_en_i = '0;
   logic        cpu_ready_o;
   logic        cpu_done_o;
   logic [31:0] cpu_rdata_o;
   logic        mem_req_o;
   logic        mem_write_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic        mem_ack_i = 1'b0;
   logic [31:0] mem_rdata_i = '0;
   logic        mem_rvalid_i = 1'b0;
   logic        inval_i = 1'b0;
   logic [31:0] inval_addr_i = '0;
   logic        inval_done_o;
`ifdef DCACHE_STATS_EN
   logic [31:0] hit_count_o;
   logic [31:0] miss_count_o;
`endif

   always #5 clk = ~clk;

   data_cache_assoc_wb dut (
      .clk_i(clk), .rst_i(rst),
      .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
      .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
      .cpu_byte_en_i(cpu_byte_en_i), .cpu_ready_o(cpu_ready_o),
      .cpu_done_o(cpu_done_o), .cpu_rdata_o(cpu_rdata_o),
      .mem_req_o(mem_req_o), .mem_write_o(mem_write_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .mem_rvalid_i(mem_rvalid_i), .inval_i(inval_i),
      .inval_addr_i(inval_addr_i), .inval_done_o(inval_done_o)
`ifdef DCACHE_STATS_EN
      , .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
`endif
   );

   int tests = 0;
   int fails = 0;

   logic [31:0] bus_mem [0:1023];
   logic [31:0] gold    [0:1023];

   // Victim-select LFSR as described: 8-bit Galois, x^8+x^6+x^5+x^4+1
   logic [7:0] tb_lfsr;
   always @(posedge clk or posedge rst)
      if (rst) tb_lfsr <= 8'h01;
      else tb_lfsr <= {1'b0, tb_lfsr[7:1]} ^ (tb_lfsr[0] ? 8'hB8 : 8'h00);

   logic [31:0] op_rdata;
   int          op_lat, op_wb, op_rf;
   logic [31:0] op_wb_addr, op_rf_addr;
   logic [7:0]  lk_lfsr;
   bit          rand_stall = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old,
                                         input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
      return r;
   endfunction

   // One CPU or invalidate operation, serving the memory side as it goes
   task automatic run_op(input bit inv, input bit w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be);
      int wbb, rfb, wi;
      bit got;
      op_wb = 0; op_rf = 0; wbb = 0; rfb = 0; got = 0;
      op_wb_addr = '1; op_rf_addr = '1; op_rdata = 'x;
      @(negedge clk);
      check("ready_before_op", cpu_ready_o, 1);
      if (inv) begin
         inval_i = 1; inval_addr_i = a;
      end else begin
         cpu_req_i = 1; cpu_write_i = w; cpu_addr_i = a;
         cpu_wdata_i = wd; cpu_byte_en_i = be;
      end
      @(posedge clk);
      #1;
      cpu_req_i = 0; inval_i = 0;
      lk_lfsr = tb_lfsr;
      op_lat = 1;
      for (int i = 0; i < 200 && !got; i++) begin
         @(negedge clk);
         if (inv ? inval_done_o : cpu_done_o) begin
            got = 1;
            op_rdata = cpu_rdata_o;
         end else begin
            mem_ack_i = 0; mem_rvalid_i = 0;
            if (mem_req_o && !(rand_stall && $urandom_range(3) == 0)) begin
               wi = (int'(mem_addr_o >> 2) + (mem_write_o ? wbb : rfb)) % 1024;
               if (mem_write_o) begin
                  if (op_wb == 0) op_wb_addr = mem_addr_o;
                  check("wb_data", mem_wdata_o, gold[wi]);
                  bus_mem[wi] = mem_wdata_o;
                  mem_ack_i = 1; wbb = (wbb + 1) % 4; op_wb++;
               end else begin
                  if (op_rf == 0) op_rf_addr = mem_addr_o;
                  mem_rdata_i = bus_mem[wi];
                  mem_rvalid_i = 1; rfb = (rfb + 1) % 4; op_rf++;
               end
            end
            @(posedge clk);
            op_lat++;
         end
      end
      mem_ack_i = 0; mem_rvalid_i = 0;
      if (!got) begin
         check("op_timeout", 0, 1);
      end else begin
         @(negedge clk);
         check("done_pulse_width", {30'd0, cpu_done_o, inval_done_o}, 0);
         if (!inv && w) gold[a[11:2]] = merge(gold[a[11:2]], wd, be);
      end
   endtask

   typedef struct {
      bit          w;
      logic [31:0] a;
      logic [31:0] wd;
      logic [3:0]  be;
      logic [31:0] exp;
      bit          miss;
   } vec_t;

   vec_t vt [7];
   logic [31:0] surv, victim_addr, ra, rd;
   int beats, r;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 1024; i++) bus_mem[i] = 32'hC0DE0000 + i;
      bus_mem[16] = 32'h11; bus_mem[17] = 32'h22;
      bus_mem[18] = 32'h33; bus_mem[19] = 32'h44;
      for (int i = 32; i < 36; i++) bus_mem[i] = 32'h11111111;
      for (int i = 0; i < 1024; i++) gold[i] = bus_mem[i];

      vt[0] = '{0, 32'h040, 32'h0, 4'h0, 32'h11, 1};
      vt[1] = '{0, 32'h044, 32'h0, 4'h0, 32'h22, 0};
      vt[2] = '{1, 32'h040, 32'hAABBCCDD, 4'b0010, 32'h0, 0};
      vt[3] = '{0, 32'h040, 32'h0, 4'h0, 32'h0000CC11, 0};
      vt[4] = '{1, 32'h080, 32'hAABBCCDD, 4'b0010, 32'h0, 1};
      vt[5] = '{0, 32'h080, 32'h0, 4'h0, 32'h1111CC11, 0};
      vt[6] = '{0, 32'h08C, 32'h0, 4'h0, 32'h11111111, 0};

      rst = 1;
      repeat (3) @(negedge clk);
      check("rst_ready", cpu_ready_o, 1);
      check("rst_done", cpu_done_o, 0);
      check("rst_rdata", cpu_rdata_o, 0);
      check("rst_mem_req", mem_req_o, 0);
      check("rst_mem_write", mem_write_o, 0);
      check("rst_mem_addr", mem_addr_o, 0);
      check("rst_inval_done", inval_done_o, 0);
`ifdef DCACHE_STATS_EN
      check("rst_hit_count", hit_count_o, 0);
      check("rst_miss_count", miss_count_o, 0);
`endif
      rst = 0;

      for (int i = 0; i < 7; i++) begin
         run_op(0, vt[i].w, vt[i].a, vt[i].wd, vt[i].be);
         if (!vt[i].w) check($sformatf("v%0d_rdata", i), op_rdata, vt[i].exp);
         check($sformatf("v%0d_miss", i), 32'(op_rf != 0), 32'(vt[i].miss));
         check($sformatf("v%0d_wb", i), op_wb, 0);
         if (vt[i].miss) check($sformatf("v%0d_rf_addr", i), op_rf_addr, vt[i].a & ~32'hF);
         else check($sformatf("v%0d_lat", i), op_lat, 2);
      end

      // Two dirty lines in set 4, then a third line forces an eviction
      run_op(0, 1, 32'h440, 32'h44044044, 4'hF);
      check("st440_no_wb", op_wb, 0);
      check("st440_refill", op_rf, 4);
      run_op(0, 0, 32'h840, 32'h0, 4'h0);
      victim_addr = lk_lfsr[0] ? 32'h440 : 32'h040;
      surv        = lk_lfsr[0] ? 32'h040 : 32'h440;
      check("evict_wb_beats", op_wb, 4);
      check("evict_wb_addr", op_wb_addr, victim_addr);
      check("evict_rf_addr", op_rf_addr, 32'h840);
      check("evict_rdata", op_rdata, gold[32'h840 >> 2]);
      run_op(0, 0, surv, 32'h0, 4'h0);
      check("surv_hit", op_wb + op_rf, 0);
      check("surv_rdata", op_rdata, gold[surv[11:2]]);

      // Invalidate a dirty line, then an absent one
      run_op(1, 0, surv, 32'h0, 4'h0);
      check("inval_wb_beats", op_wb, 4);
      check("inval_wb_addr", op_wb_addr, surv);
      check("inval_no_refill", op_rf, 0);
      run_op(0, 0, surv, 32'h0, 4'h0);
      check("after_inval_miss", op_rf, 4);
      check("after_inval_rdata", op_rdata, gold[surv[11:2]]);
      run_op(1, 0, 32'hC40, 32'h0, 4'h0);
      check("inval_absent_lat", op_lat, 2);
      check("inval_absent_mem", op_wb + op_rf, 0);

      // Reset in the middle of a refill burst
      @(negedge clk);
      cpu_req_i = 1; cpu_write_i = 0; cpu_addr_i = 32'h0C0;
      @(posedge clk);
      #1 cpu_req_i = 0;
      beats = 0;
      for (int i = 0; i < 20 && beats < 2; i++) begin
         @(negedge clk);
         mem_rvalid_i = 0;
         if (mem_req_o && !mem_write_o) begin
            mem_rdata_i = bus_mem[(32'h0C0 >> 2) + beats];
            mem_rvalid_i = 1;
            beats++;
         end
         @(posedge clk);
      end
      check("rst_mid_beats", beats, 2);
      #1 rst = 1; mem_rvalid_i = 0;
      #1 check("rst_mid_mem_req", mem_req_o, 0);
      check("rst_mid_done", cpu_done_o, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      @(negedge clk);
      check("rst_mid_ready", cpu_ready_o, 1);
      for (int i = 0; i < 1024; i++) gold[i] = bus_mem[i];
      run_op(0, 0, 32'h0C0, 32'h0, 4'h0);
      check("post_rst_miss", op_rf, 4);
      check("post_rst_rdata", op_rdata, gold[32'h0C0 >> 2]);
      run_op(0, 0, 32'h0C4, 32'h0, 4'h0);
      check("post_rst_hit1", op_rf, 0);
      run_op(0, 0, 32'h0C8, 32'h0, 4'h0);
      check("post_rst_hit2", op_rf, 0);
      run_op(0, 1, 32'h0C0, 32'h12345678, 4'hF);
      check("post_rst_st_hit", op_rf, 0);
`ifdef DCACHE_STATS_EN
      check("hit_count", hit_count_o, 3);
      check("miss_count", miss_count_o, 1);
`endif

      // Randomized traffic over a few conflicting lines
      rand_stall = 1;
      for (int n = 0; n < 300; n++) begin
         ra = (32'($urandom_range(3)) << 8) | (32'($urandom_range(1)) << 4) |
              (32'($urandom_range(3)) << 2);
         rd = $urandom;
         r  = $urandom_range(15);
         if (r == 0) begin
            run_op(1, 0, ra, 32'h0, 4'h0);
            check("rnd_inval_no_refill", op_rf, 0);
         end else if (r < 7) begin
            run_op(0, 1, ra, rd, 4'($urandom_range(15)));
         end else begin
            run_op(0, 0, ra, 32'h0, 4'h0);
            check("rnd_load", op_rdata, gold[ra[11:2]]);
         end
         if (op_wb + op_rf == 0) check("rnd_lat", op_lat, 2);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
